// File: rtl/seq_mult_ctrl_if.sv
// rtl/seq_mult_ctrl_if.sv - request/response bundle for the sequential multiplier
//
// Purpose: groups the operand request and the product response of seq_mult_ctrl.
// Ports (signals):
//   start, enable, signed_mode      requester -> multiplier control
//   multiplicand, multiplier        requester -> multiplier operands (WIDTH bits)
//   l_s, busy, done                 multiplier -> requester status
//   product                         multiplier -> requester result (2*WIDTH bits)
// Modports: master = requester side, slave = multiplier side.
interface seq_mult_ctrl_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               enable;
  logic               signed_mode;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               l_s;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, enable, signed_mode, multiplicand, multiplier,
    input  l_s, busy, done, product
  );

  modport slave (
    input  start, enable, signed_mode, multiplicand, multiplier,
    output l_s, busy, done, product
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// rtl/seq_mult_ctrl.sv - radix-2 shift-add sequential multiplier with controller FSM
//
// Purpose: one 2*WIDTH-bit product per accepted start, signed or unsigned,
//          stepping one multiplier bit per enabled cycle.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset
//   bus   slave modport of seq_mult_ctrl_if (start/enable/signed_mode/operands in,
//         l_s/busy/done/product out)
module seq_mult_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input logic            clk,
  input logic            rst,
  seq_mult_ctrl_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MULT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             sgn_q, sgn_d, neg_q, neg_d;
  logic [PW-1:0]    mcand_q, mcand_d, acc_q, acc_d, product_q, product_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      neg_q     <= 1'b0;
      mplier_q  <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      neg_q     <= neg_d;
      mplier_q  <= mplier_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    // Unary minus on WIDTH bits maps -2^(WIDTH-1) onto 2^(WIDTH-1), which is
    // exactly the unsigned magnitude we need.
    a_mag    = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag    = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    neg_d     = neg_q;
    mplier_d  = mplier_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.multiplicand;
          b_d     = bus.multiplier;
          sgn_d   = bus.signed_mode & SIGNED_EN;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        mcand_d  = {{WIDTH{1'b0}}, a_mag};
        mplier_d = b_mag;
        neg_d    = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = S_MULT;
      end
      S_MULT: begin
        if (bus.enable) begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            // A zero magnitude negates to zero, so no special case for -0.
            product_d = neg_q ? -acc_step : acc_step;
            state_d   = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.l_s     = (state_q == S_LOAD);
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.product = product_q;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb/tb_seq_mult_ctrl.sv - scoreboard bench for seq_mult_ctrl (WIDTH=8)
module tb_seq_mult_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  typedef struct {
    logic [15:0] prod;
    int          done_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  seq_mult_ctrl_if #(.WIDTH(8)) bus ();

  seq_mult_ctrl #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_product"}, 32'(bus.product), 32'(e.prod));
        chk({e.name, "_done_cycle"}, cyc, e.done_cyc);
      end
    end
  end

  task automatic wait_done(input string name);
    int k = 0;
    while (!bus.done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_timeout: done=0 after %0d cycles, expected 1", name, k);
    end
  endtask

  task automatic op(input string name, input logic [7:0] a, input logic [7:0] b,
                    input logic sm, input logic [15:0] exp_p, input int stall);
    @(negedge clk);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.signed_mode  = sm;
    bus.start        = 1'b1;
    sb.push_back('{exp_p, cyc + 10 + stall, name});
    @(negedge clk);
    bus.start = 1'b0;
    chk({name, "_l_s"}, 32'(bus.l_s), 32'd1);
    chk({name, "_busy"}, 32'(bus.busy), 32'd1);
    if (stall > 0) begin
      @(negedge clk);
      bus.enable = 1'b0;
      repeat (stall) @(negedge clk);
      bus.enable = 1'b1;
    end
    wait_done(name);
    @(negedge clk);
    chk({name, "_busy_after"}, 32'(bus.busy), 32'd0);
    chk({name, "_held"}, 32'(bus.product), 32'(exp_p));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.enable       = 1'b1;
    bus.signed_mode  = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (2) @(negedge clk);
    chk("rst_product", 32'(bus.product), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_l_s", 32'(bus.l_s), 32'd0);
    rst = 1'b0;

    op("u13x11",   8'd13,  8'd11,  1'b0, 16'h008F, 0);
    op("u255x255", 8'hFF,  8'hFF,  1'b0, 16'hFE01, 0);
    op("s-7x5",    8'hF9,  8'h05,  1'b1, 16'hFFDD, 0);
    op("uF9x05",   8'hF9,  8'h05,  1'b0, 16'h04DD, 0);
    op("s-128x-128", 8'h80, 8'h80, 1'b1, 16'h4000, 0);
    op("s-128x1",  8'h80,  8'h01,  1'b1, 16'hFF80, 0);
    op("s127x-127", 8'h7F, 8'h81,  1'b1, 16'hC0FF, 0);
    op("s0x-128",  8'h00,  8'h80,  1'b1, 16'h0000, 0);
    op("stall3",   8'd13,  8'd11,  1'b0, 16'h008F, 3);

    // Restarts while busy and mid-op operand changes must not disturb the result.
    @(negedge clk);
    bus.multiplicand = 8'd13;
    bus.multiplier   = 8'd11;
    bus.signed_mode  = 1'b0;
    bus.start        = 1'b1;
    sb.push_back('{16'h008F, cyc + 10, "busy_start"});
    @(negedge clk);
    bus.start        = 1'b0;
    bus.multiplicand = 8'hFF;
    bus.multiplier   = 8'h80;
    bus.signed_mode  = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("busy_start");
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_start_busy", 32'(bus.busy), 32'd0);
    repeat (14) @(negedge clk);
    chk("done_start_ignored_busy", 32'(bus.busy), 32'd0);
    chk("done_start_product", 32'(bus.product), 32'h008F);

    // Reset in cycle 5 of an operation aborts it with no done pulse.
    @(negedge clk);
    bus.multiplicand = 8'hFF;
    bus.multiplier   = 8'hFF;
    bus.signed_mode  = 1'b0;
    bus.start        = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < t0 + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_product", 32'(bus.product), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    op("after_rst", 8'h80, 8'h80, 1'b0, 16'h4000, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
